irda_mir_tx_datapath: RTL and testbench
=======================================

Name: irda_mir_tx_datapath

Overview:
- Serial bit-level datapath of the IrDA MIR (1.152 Mb/s) transmitter; groups the three leaf functions the MIR transmit FSM drives: STA/STO flag generator, HDLC zero-bit stuffer, CRC-CCITT16 FCS generator.
- The FSM owns sequencing and the output mux; this block owns the bit-level state, advanced only on cycles where its enable is high.

Parameters:
- FLAG, 8'h7E, flag pattern emitted by the STA/STO generator.
- CRC_INIT, 16'hFFFF, CRC preset value.
- CRC_POLY, 16'h8408, reflected CCITT polynomial (x^16+x^12+x^5+1).

Ports:
- clk  in  1  system clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- mir_txbit_enable  in  1  MIR bit-time strobe for flag generator and stuffer.
- st_restart  in  1  reload the flag register.
- st_shift  in  1  advance the flag register one bit.
- st_out  out  1  current flag bit.
- bs_restart  in  1  clear the stuffer ones-run counter.
- stuffer_i  in  1  bit to be stuffed.
- stuffer_o  out  1  stuffed output bit.
- shift_req_o  out  1  1 = stuffer_i consumed this bit time; 0 = stuffed zero being sent.
- clrcrc  in  1  preset the CRC register.
- txdin  in  1  data bit for the CRC.
- crcndata  in  1  0 = accumulate txdin; 1 = shift FCS out.
- crc_txbit_enable  in  1  CRC strobe; the FSM drives it as mir_txbit_enable AND shift_req_o.
- bdcrc  in  1  debug: invert the FCS output bits.
- txdout  out  1  FCS bit, or txdin pass-through.
- crc_o  out  16  current CRC register value.

Behaviour:
- All state changes on the rising edge of clk; wb_rst_i has top priority over every other input.
- Flag generator, state:
  - 8-bit register flag_r; reset value is FLAG.
  - st_out = flag_r[0], combinational; reset value 0.
- Flag generator, per edge with mir_txbit_enable=1:
  - st_restart=1: flag_r <= FLAG; takes priority over st_shift.
  - otherwise st_shift=1: rotate right by one (bit 0 moves to bit 7).
  - with mir_txbit_enable=0: hold.
- Flag generator, stream: continuous shifting yields 0,1,1,1,1,1,1,0 repeating. 8 shifts = one flag; the STA sequence is 16 bits, the STO sequence 8 bits.
- Stuffer, state: 3-bit ones counter cnt; reset value 0.
- Stuffer outputs, combinational:
  - cnt==5: stuffer_o=0 and shift_req_o=0.
  - otherwise: stuffer_o=stuffer_i and shift_req_o=1.
  - Reset outputs: shift_req_o=1, stuffer_o follows stuffer_i.
- Stuffer, per edge with mir_txbit_enable=1:
  - bs_restart=1: cnt <= 0.
  - else cnt==5: cnt <= 0 (the stuffed zero breaks the run).
  - else stuffer_i=1: cnt <= cnt+1.
  - else: cnt <= 0.
- Stuffer boundary: cnt never exceeds 5. Six input ones produce 1,1,1,1,1,0,1, and the sixth input one is presented during the stuffed-zero slot.
- CRC, state: 16-bit register crc; reset value CRC_INIT; crc_o = crc.
- CRC, per edge:
  - clrcrc=1: crc <= CRC_INIT, regardless of enable.
  - else crc_txbit_enable=1 and crcndata=0: fb = crc[0]^txdin; crc <= (crc>>1) XOR (fb ? CRC_POLY : 0). Bits are taken LSB-first.
  - else crc_txbit_enable=1 and crcndata=1: crc <= {1'b1, crc[15:1]}.
- txdout:
  - crcndata=1: ~crc[0] ^ bdcrc, giving the complemented FCS LSB-first over 16 strobes.
  - crcndata=0: txdin.
- CRC boundary: clrcrc together with an enable applies clrcrc only. Running the CRC over data followed by its transmitted FCS leaves crc = 16'hF0B8.

Test Plan:
- Reset, then st_restart with enable, then 16 st_shift strobes -> st_out = 0111 1110 0111 1110, read first to last bit; enable held low -> st_out frozen.
- Stuffer fed 8 ones with bs_restart=0 -> stuffer_o = 1,1,1,1,1,0,1,1,1; shift_req_o=0 only in the 6th slot.
- Stuffer fed 1,1,1,1,0,1,1,1,1,1 -> no insertion at the first 0; insertion after the final five ones. bs_restart mid-run clears cnt.
- CRC, clrcrc, then ASCII "123456789" LSB-first per byte -> crc_o = 16'h6F91. Then crcndata=1 for 16 strobes -> txdout bits equal 16'h906E LSB-first.
- Data bits followed by their FCS fed back through txdin -> crc_o = 16'hF0B8. Same run with bdcrc=1 -> every FCS bit inverted.
- Reset asserted mid-frame (cnt=3, crc partially updated) -> next cycle cnt=0, crc_o=16'hFFFF, st_out=0.

Source files
------------

// File: rtl/irda_mir_tx_datapath.sv
// Purpose : bit-level datapath of the IrDA MIR transmitter: STA/STO flag shifter, HDLC zero-bit stuffer, CRC-CCITT16 FCS.
// Latency : outputs are combinational from registered state; state advances one step per enabled clock edge.
// Backpres: stuffer drops shift_req_o for one bit time while it inserts a stuffed zero; the caller holds stuffer_i.
//
// Ports:
//   clk, wb_rst_i                    clock, synchronous active-high reset (highest priority)
//   mir_txbit_enable                 MIR bit-time strobe for the flag generator and the stuffer
//   st_restart, st_shift, st_out     flag register reload / rotate, current flag bit
//   bs_restart, stuffer_i            stuffer run-counter clear, bit to be stuffed
//   stuffer_o, shift_req_o           stuffed bit, 1 = stuffer_i consumed this bit time
//   clrcrc, txdin, crcndata          CRC preset, data bit, 0 = accumulate / 1 = shift FCS out
//   crc_txbit_enable, bdcrc          CRC strobe, invert FCS output bits
//   txdout, crc_o                    FCS bit or txdin pass-through, current CRC register

module irda_mir_tx_datapath #(
    parameter logic [7:0]  FLAG     = 8'h7E,
    parameter logic [15:0] CRC_INIT = 16'hFFFF,
    parameter logic [15:0] CRC_POLY = 16'h8408
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        mir_txbit_enable,
    input  logic        st_restart,
    input  logic        st_shift,
    output logic        st_out,
    input  logic        bs_restart,
    input  logic        stuffer_i,
    output logic        stuffer_o,
    output logic        shift_req_o,
    input  logic        clrcrc,
    input  logic        txdin,
    input  logic        crcndata,
    input  logic        crc_txbit_enable,
    input  logic        bdcrc,
    output logic        txdout,
    output logic [15:0] crc_o
);

    // ------------------------------------------------------------------
    // Flag generator: rotate right so the flag is emitted LSB-first and
    // repeats every 8 shifts without needing a reload.
    // ------------------------------------------------------------------
    logic [7:0] flag_r;

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            flag_r <= FLAG;
        end else if (mir_txbit_enable) begin
            if (st_restart) begin
                flag_r <= FLAG;
            end else if (st_shift) begin
                flag_r <= {flag_r[0], flag_r[7:1]};
            end
        end
    end

    assign st_out = flag_r[0];

    // ------------------------------------------------------------------
    // Zero-bit stuffer: cnt counts consecutive ones already sent. When it
    // reaches five, the current bit time carries a stuffed zero and the
    // input bit is left unconsumed for the next bit time.
    // ------------------------------------------------------------------
    localparam logic [2:0] RUN_MAX = 3'd5;

    logic [2:0] cnt;
    logic       stuff_slot;

    assign stuff_slot = (cnt == RUN_MAX);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            cnt <= 3'd0;
        end else if (mir_txbit_enable) begin
            if (bs_restart) begin
                cnt <= 3'd0;
            end else if (stuff_slot) begin
                // the stuffed zero itself breaks the run of ones
                cnt <= 3'd0;
            end else if (stuffer_i) begin
                cnt <= cnt + 3'd1;
            end else begin
                cnt <= 3'd0;
            end
        end
    end

    assign stuffer_o   = stuff_slot ? 1'b0 : stuffer_i;
    assign shift_req_o = ~stuff_slot;

    // ------------------------------------------------------------------
    // CRC-CCITT16, reflected form, LSB-first. While shifting the FCS out,
    // ones are shifted in from the top so the register ends at all ones.
    // ------------------------------------------------------------------
    logic [15:0] crc;
    logic        crc_fb;
    logic [15:0] crc_next_data;

    assign crc_fb        = crc[0] ^ txdin;
    assign crc_next_data = (crc >> 1) ^ (crc_fb ? CRC_POLY : 16'h0000);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            crc <= CRC_INIT;
        end else if (clrcrc) begin
            // preset wins over the strobe so a frame start never absorbs a bit
            crc <= CRC_INIT;
        end else if (crc_txbit_enable) begin
            if (!crcndata) begin
                crc <= crc_next_data;
            end else begin
                crc <= {1'b1, crc[15:1]};
            end
        end
    end

    // FCS is sent complemented; bdcrc flips it again for debug corruption
    assign txdout = crcndata ? (~crc[0] ^ bdcrc) : txdin;
    assign crc_o  = crc;

endmodule

// File: tb/tb_irda_mir_tx_datapath.sv
module tb_irda_mir_tx_datapath;

    logic        clk;
    logic        wb_rst_i;
    logic        mir_txbit_enable;
    logic        st_restart;
    logic        st_shift;
    logic        st_out;
    logic        bs_restart;
    logic        stuffer_i;
    logic        stuffer_o;
    logic        shift_req_o;
    logic        clrcrc;
    logic        txdin;
    logic        crcndata;
    logic        crc_txbit_enable;
    logic        bdcrc;
    logic        txdout;
    logic [15:0] crc_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  flag_v;
    logic [15:0] ref_crc;
    logic [15:0] fcs;
    logic [7:0]  data_q[$];
    logic        bits_q[$];
    int          k;

    irda_mir_tx_datapath dut (
        .clk              (clk),
        .wb_rst_i         (wb_rst_i),
        .mir_txbit_enable (mir_txbit_enable),
        .st_restart       (st_restart),
        .st_shift         (st_shift),
        .st_out           (st_out),
        .bs_restart       (bs_restart),
        .stuffer_i        (stuffer_i),
        .stuffer_o        (stuffer_o),
        .shift_req_o      (shift_req_o),
        .clrcrc           (clrcrc),
        .txdin            (txdin),
        .crcndata         (crcndata),
        .crc_txbit_enable (crc_txbit_enable),
        .bdcrc            (bdcrc),
        .txdout           (txdout),
        .crc_o            (crc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Software-style byte-wise CRC-CCITT (X.25 register, no final xor)
    function automatic logic [15:0] crc_of(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[i]) begin
            c = c ^ {8'h00, d[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    task automatic feed_bit(input logic b);
        txdin            = b;
        crcndata         = 1'b0;
        crc_txbit_enable = 1'b1;
        #1;
        chk("txdout_pass", {15'd0, txdout}, {15'd0, b});
        tick();
        crc_txbit_enable = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) feed_bit(v[i]);
    endtask

    task automatic do_clrcrc();
        clrcrc = 1'b1;
        tick();
        clrcrc = 1'b0;
    endtask

    // Build a bit list from a vector, first bit = leftmost
    function automatic void vec_bits(input logic [63:0] v, input int n);
        bits_q.delete();
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
    endfunction

    // HDLC rule: after five consecutive ones on the line, insert a zero.
    task automatic run_stuff(input logic bits[$], input string tag, input bit do_clr);
        logic eo[$];
        logic er[$];
        int   ones;
        int   idx;
        ones = 0;
        foreach (bits[i]) begin
            eo.push_back(bits[i]);
            er.push_back(1'b1);
            ones = bits[i] ? ones + 1 : 0;
            if (ones == 5) begin
                eo.push_back(1'b0);
                er.push_back(1'b0);
                ones = 0;
            end
        end
        st_shift   = 1'b0;
        st_restart = 1'b0;
        if (do_clr) begin
            mir_txbit_enable = 1'b1;
            bs_restart       = 1'b1;
            stuffer_i        = 1'b0;
            tick();
            bs_restart = 1'b0;
        end
        idx = 0;
        for (int j = 0; j < eo.size(); j++) begin
            if ($urandom_range(0, 3) == 0) begin
                mir_txbit_enable = 1'b0;
                stuffer_i        = 1'($urandom);
                tick();
            end
            mir_txbit_enable = 1'b1;
            stuffer_i        = (idx < bits.size()) ? bits[idx] : 1'b0;
            #1;
            chk($sformatf("%s_out[%0d]", tag, j), {15'd0, stuffer_o},   {15'd0, eo[j]});
            chk($sformatf("%s_req[%0d]", tag, j), {15'd0, shift_req_o}, {15'd0, er[j]});
            if (er[j]) idx++;
            tick();
        end
        mir_txbit_enable = 1'b0;
    endtask

    initial begin
        flag_v           = 8'h7E;
        wb_rst_i         = 1'b1;
        mir_txbit_enable = 1'b0;
        st_restart       = 1'b0;
        st_shift         = 1'b0;
        bs_restart       = 1'b0;
        stuffer_i        = 1'b0;
        clrcrc           = 1'b0;
        txdin            = 1'b0;
        crcndata         = 1'b0;
        crc_txbit_enable = 1'b0;
        bdcrc            = 1'b0;
        tick();
        tick();
        wb_rst_i = 1'b0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_st_out", {15'd0, st_out}, 16'd0);
        chk("rst_shift_req", {15'd0, shift_req_o}, 16'd1);
        chk("rst_crc", crc_o, 16'hFFFF);
        stuffer_i = 1'b1;
        #1;
        chk("rst_stuffer_o_1", {15'd0, stuffer_o}, 16'd1);
        stuffer_i = 1'b0;
        txdin     = 1'b1;
        #1;
        chk("rst_stuffer_o_0", {15'd0, stuffer_o}, 16'd0);
        chk("rst_txdout", {15'd0, txdout}, 16'd1);
        txdin = 1'b0;

        // ---------------- flag generator, directed ----------------
        mir_txbit_enable = 1'b1;
        st_restart       = 1'b1;
        tick();
        st_restart = 1'b0;
        st_shift   = 1'b1;
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("flag_bit[%0d]", i), {15'd0, st_out}, {15'd0, flag_v[i % 8]});
            if (i < 17) tick();
        end
        // now at bit 1 (value 1): hold with enable low while shift requested
        mir_txbit_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("flag_hold[%0d]", i), {15'd0, st_out}, 16'd1);
        end

        // ---------------- flag generator, random ----------------
        k = 1;
        for (int i = 0; i < 60; i++) begin
            logic en, rs, sh;
            en = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 7) == 0);
            sh = ($urandom_range(0, 3) != 0);
            mir_txbit_enable = en;
            st_restart       = rs;
            st_shift         = sh;
            tick();
            if (en) begin
                if (rs) k = 0;
                else if (sh) k = k + 1;
            end
            chk($sformatf("flag_rand[%0d]", i), {15'd0, st_out}, {15'd0, flag_v[k % 8]});
        end
        mir_txbit_enable = 1'b0;
        st_restart       = 1'b0;
        st_shift         = 1'b0;

        // ---------------- stuffer, directed ----------------
        vec_bits(64'hFF, 8);
        run_stuff(bits_q, "stuff8", 1'b1);
        vec_bits(64'b1111011111, 10);
        run_stuff(bits_q, "stuffmix", 1'b1);

        // bs_restart mid-run: three ones, then a restart slot, then five ones
        vec_bits(64'b111, 3);
        run_stuff(bits_q, "pre_rs", 1'b1);
        mir_txbit_enable = 1'b1;
        bs_restart       = 1'b1;
        stuffer_i        = 1'b1;
        #1;
        chk("rs_slot_req", {15'd0, shift_req_o}, 16'd1);
        tick();
        bs_restart = 1'b0;
        vec_bits(64'b11111, 5);
        run_stuff(bits_q, "post_rs", 1'b0);

        // ---------------- stuffer, random ----------------
        for (int r = 0; r < 3; r++) begin
            bits_q.delete();
            for (int i = 0; i < 40; i++) bits_q.push_back($urandom_range(0, 4) != 0);
            run_stuff(bits_q, $sformatf("stuffrnd%0d", r), 1'b1);
        end

        // ---------------- CRC check string ----------------
        data_q.delete();
        for (int i = 0; i < 9; i++) data_q.push_back(8'h31 + 8'(i));
        do_clrcrc();
        foreach (data_q[i]) feed_byte(data_q[i]);
        chk("crc_123456789", crc_o, 16'h6F91);
        chk("crc_123456789_model", crc_o, crc_of(data_q));
        fcs = 16'h906E;
        crcndata         = 1'b1;
        crc_txbit_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("fcs_bit[%0d]", i), {15'd0, txdout}, {15'd0, fcs[i]});
            tick();
        end
        crc_txbit_enable = 1'b0;
        crcndata         = 1'b0;
        chk("crc_after_fcs", crc_o, 16'hFFFF);

        // ---------------- random data + FCS residue, bdcrc ----------------
        for (int r = 0; r < 3; r++) begin
            data_q.delete();
            for (int i = 0; i < int'($urandom_range(3, 8)); i++) data_q.push_back(8'($urandom));
            ref_crc = crc_of(data_q);
            fcs     = ~ref_crc;

            do_clrcrc();
            foreach (data_q[i]) feed_byte(data_q[i]);
            chk($sformatf("rnd_crc[%0d]", r), crc_o, ref_crc);
            // strobe low must hold the register
            for (int i = 0; i < 3; i++) begin
                txdin    = 1'($urandom);
                crcndata = 1'($urandom);
                tick();
            end
            crcndata = 1'b0;
            chk($sformatf("rnd_hold[%0d]", r), crc_o, ref_crc);
            // shift FCS out, inverted when bdcrc is set on odd runs
            bdcrc            = 1'(r % 2);
            crcndata         = 1'b1;
            crc_txbit_enable = 1'b1;
            for (int i = 0; i < 16; i++) begin
                #1;
                chk($sformatf("rnd_fcs%0d_bit[%0d]", r, i), {15'd0, txdout},
                    {15'd0, fcs[i] ^ bdcrc});
                tick();
            end
            crc_txbit_enable = 1'b0;
            crcndata         = 1'b0;
            bdcrc            = 1'b0;

            // data followed by its FCS leaves the good-frame residue
            do_clrcrc();
            foreach (data_q[i]) feed_byte(data_q[i]);
            feed_byte(fcs[7:0]);
            feed_byte(fcs[15:8]);
            chk($sformatf("residue[%0d]", r), crc_o, 16'hF0B8);
        end

        // clrcrc together with the strobe applies only the preset
        feed_byte(8'hA5);
        clrcrc           = 1'b1;
        crc_txbit_enable = 1'b1;
        txdin            = 1'b1;
        tick();
        chk("clr_with_en", crc_o, 16'hFFFF);
        clrcrc           = 1'b0;
        crc_txbit_enable = 1'b0;

        // ---------------- reset mid-frame ----------------
        vec_bits(64'b111, 3);
        run_stuff(bits_q, "pre_rst", 1'b1);      // cnt now 3
        feed_byte(8'h5A);                        // crc partially updated
        mir_txbit_enable = 1'b1;
        st_restart       = 1'b1;
        tick();
        st_restart = 1'b0;
        st_shift   = 1'b1;
        tick();                                  // st_out now 1
        chk("pre_rst_st_out", {15'd0, st_out}, 16'd1);
        wb_rst_i         = 1'b1;
        stuffer_i        = 1'b1;
        crc_txbit_enable = 1'b1;
        txdin            = 1'b1;
        tick();
        chk("midrst_crc", crc_o, 16'hFFFF);
        chk("midrst_st_out", {15'd0, st_out}, 16'd0);
        chk("midrst_shift_req", {15'd0, shift_req_o}, 16'd1);
        wb_rst_i         = 1'b0;
        st_shift         = 1'b0;
        crc_txbit_enable = 1'b0;
        txdin            = 1'b0;
        // cnt must restart from zero: stuffing only after five fresh ones
        vec_bits(64'b111111, 6);
        run_stuff(bits_q, "post_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
